mem_port_arbiter: RTL and testbench

Shares the single synchronous data SRAM port between the instruction-fetch requester and the execute-stage data requester. Grants at most one access per cycle with a req/addr_ok, data_ok/rsp_ready handshake and routes the 1-cycle-latency SRAM response back to its owner. A per-port one-entry response buffer absorbs back-pressure. Sits between the pipeline stages and the SRAM macro, replacing the direct stage-to-SRAM wiring.

---
 rtl/mem_port_arbiter_pkg.sv | 31 +++
 rtl/mem_arb_rsp_buffer.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the SRAM port arbiter: requester identity, in-flight tracking
// and the request/response bundles at their default widths.
package mem_arb_params;

   localparam int unsigned MEM_ADDRESS_WIDTH = 32;
   localparam int unsigned MEM_DATA_WIDTH    = 32;

   typedef enum logic {
      REQ_INST = 1'b0,
      REQ_DATA = 1'b1
   } Requester;

   typedef struct packed {
      logic                          valid;
      logic [MEM_DATA_WIDTH/8-1:0]   write_enabled;
      logic [MEM_ADDRESS_WIDTH-1:0]  address;
      logic [MEM_DATA_WIDTH-1:0]     write_data;
   } MemRequest;

   typedef struct packed {
      logic                       valid;
      logic [MEM_DATA_WIDTH-1:0]  data;
   } MemResponse;

   typedef struct packed {
      logic     valid;
      Requester owner;
      logic     is_write;
   } InFlight;

endpackage

// File: rtl/mem_arb_rsp_buffer.sv
// One-entry response holding register: passes a response straight through when the
// consumer is ready, otherwise parks it until rsp_ready.
module mem_arb_rsp_buffer #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  rsp_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  empty
);

   logic                  held_q;
   logic [DATA_WIDTH-1:0] held_data_q;

   // Drain and capture never coincide: the arbiter only grants a port whose buffer is empty.
   always_ff @(posedge clock) begin
      if (reset) begin
         held_q      <= 1'b0;
         held_data_q <= '0;
      end else if (held_q) begin
         if (rsp_ready) held_q <= 1'b0;
      end else if (in_valid && !rsp_ready) begin
         held_q      <= 1'b1;
         held_data_q <= in_data;
      end
   end

   always_comb begin
      out_valid = 1'b0;
      out_data  = '0;
      if (!reset) begin
         if (held_q) begin
            out_valid = 1'b1;
            out_data  = held_data_q;
         end else if (in_valid) begin
            out_valid = 1'b1;
            out_data  = in_data;
         end
      end
   end

   assign empty = !held_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single SRAM port between fetch and data requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin ties; default is fixed data priority.
module mem_port_arbiter
   import mem_arb_params::*;
#(
   parameter int unsigned ADDRESS_WIDTH = MEM_ADDRESS_WIDTH,
   parameter int unsigned DATA_WIDTH    = MEM_DATA_WIDTH
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      inst_req,
   input  logic [ADDRESS_WIDTH-1:0]  inst_address,
   output logic                      inst_addr_ok,
   output logic                      inst_data_ok,
   output logic [DATA_WIDTH-1:0]     inst_rdata,
   input  logic                      inst_rsp_ready,
   input  logic                      data_req,
   input  logic [DATA_WIDTH/8-1:0]   data_write_enabled,
   input  logic [ADDRESS_WIDTH-1:0]  data_address,
   input  logic [DATA_WIDTH-1:0]     data_write_data,
   output logic                      data_addr_ok,
   output logic                      data_data_ok,
   output logic [DATA_WIDTH-1:0]     data_rdata,
   input  logic                      data_rsp_ready,
   output logic                      sram_enabled,
   output logic [DATA_WIDTH/8-1:0]   sram_write_enabled,
   output logic [ADDRESS_WIDTH-1:0]  sram_address,
   output logic [DATA_WIDTH-1:0]     sram_write_data,
   input  logic [DATA_WIDTH-1:0]     sram_read_data
);

   InFlight inflight_q, inflight_d;

   logic                  inst_empty, data_empty;
   logic                  inst_owns, data_owns;
   logic                  inst_eligible, data_eligible;
   logic                  grant_inst, grant_data;
   logic [DATA_WIDTH-1:0] rsp_data;

   assign inst_owns = inflight_q.valid && (inflight_q.owner == REQ_INST);
   assign data_owns = inflight_q.valid && (inflight_q.owner == REQ_DATA);
   assign rsp_data  = inflight_q.is_write ? '0 : sram_read_data;

   // A port may only issue if its response path can take the result next cycle.
   assign inst_eligible = inst_empty && (!inst_owns || inst_rsp_ready);
   assign data_eligible = data_empty && (!data_owns || data_rsp_ready);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   Requester last_q;

   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (!reset) begin
         if (inst_req && inst_eligible && data_req && data_eligible) begin
            if (last_q == REQ_DATA) grant_inst = 1'b1;
            else                    grant_data = 1'b1;
         end else begin
            grant_inst = inst_req && inst_eligible;
            grant_data = data_req && data_eligible;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset)           last_q <= REQ_DATA;
      else if (grant_inst) last_q <= REQ_INST;
      else if (grant_data) last_q <= REQ_DATA;
   end
`else
   always_comb begin
      grant_data = !reset && data_req && data_eligible;
      grant_inst = !reset && inst_req && inst_eligible && !grant_data;
   end
`endif

   assign inst_addr_ok = grant_inst;
   assign data_addr_ok = grant_data;

   always_comb begin
      sram_enabled       = grant_inst || grant_data;
      sram_write_enabled = '0;
      sram_address       = '0;
      sram_write_data    = '0;
      if (grant_data) begin
         sram_write_enabled = data_write_enabled;
         sram_address       = data_address;
         sram_write_data    = data_write_data;
      end else if (grant_inst) begin
         sram_address = inst_address;
      end
   end

   always_comb begin
      inflight_d.valid    = grant_inst || grant_data;
      inflight_d.owner    = grant_data ? REQ_DATA : REQ_INST;
      inflight_d.is_write = grant_data && (|data_write_enabled);
   end

   always_ff @(posedge clock) begin
      if (reset) inflight_q <= '{valid: 1'b0, owner: REQ_INST, is_write: 1'b0};
      else       inflight_q <= inflight_d;
   end

   mem_arb_rsp_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_inst_buffer (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (inst_owns),
      .in_data   (rsp_data),
      .rsp_ready (inst_rsp_ready),
      .out_valid (inst_data_ok),
      .out_data  (inst_rdata),
      .empty     (inst_empty)
   );

   mem_arb_rsp_buffer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_data_buffer (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (data_owns),
      .in_data   (rsp_data),
      .rsp_ready (data_rsp_ready),
      .out_valid (data_data_ok),
      .out_data  (data_rdata),
      .empty     (data_empty)
   );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios followed by random traffic
// against a word-addressed reference memory; honours MEM_ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        inst_req, inst_addr_ok, inst_data_ok, inst_rsp_ready;
   logic [31:0] inst_address, inst_rdata;
   logic        data_req, data_addr_ok, data_data_ok, data_rsp_ready;
   logic [3:0]  data_write_enabled;
   logic [31:0] data_address, data_write_data, data_rdata;
   logic        sram_enabled;
   logic [3:0]  sram_write_enabled;
   logic [31:0] sram_address, sram_write_data, sram_read_data;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(
      .ADDRESS_WIDTH(32),
      .DATA_WIDTH   (32)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .inst_req           (inst_req),
      .inst_address       (inst_address),
      .inst_addr_ok       (inst_addr_ok),
      .inst_data_ok       (inst_data_ok),
      .inst_rdata         (inst_rdata),
      .inst_rsp_ready     (inst_rsp_ready),
      .data_req           (data_req),
      .data_write_enabled (data_write_enabled),
      .data_address       (data_address),
      .data_write_data    (data_write_data),
      .data_addr_ok       (data_addr_ok),
      .data_data_ok       (data_data_ok),
      .data_rdata         (data_rdata),
      .data_rsp_ready     (data_rsp_ready),
      .sram_enabled       (sram_enabled),
      .sram_write_enabled (sram_write_enabled),
      .sram_address       (sram_address),
      .sram_write_data    (sram_write_data),
      .sram_read_data     (sram_read_data)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Memory contents: SRAM model driven by DUT commands, reference driven by requests.
   logic [31:0] sram_mem [logic [31:0]];
   logic [31:0] ref_mem  [logic [31:0]];
   logic [31:0] sram_word;

   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      logic [31:0] w;
      w = ref_read(a);
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      ref_mem[a] = w;
   endtask

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      sram_mem[a] = d;
      ref_mem[a]  = d;
   endtask

   always @(posedge clock) begin
      if (sram_enabled) begin
         sram_word = sram_mem.exists(sram_address) ? sram_mem[sram_address]
                                                   : init_word(sram_address);
         sram_read_data <= sram_word;
         for (int b = 0; b < 4; b++)
            if (sram_write_enabled[b]) sram_word[8*b +: 8] = sram_write_data[8*b +: 8];
         sram_mem[sram_address] = sram_word;
      end else begin
         sram_read_data <= $urandom;
      end
   end

   // Scoreboard: expected responses queued at grant, popped when the consumer accepts.
   logic [31:0] inst_q[$];
   logic [31:0] data_q[$];
   logic        inst_hold = 1'b0, data_hold = 1'b0;
   logic [31:0] inst_hold_d, data_hold_d;

   always @(negedge clock) begin
      if (reset) begin
         inst_q.delete();
         data_q.delete();
         inst_hold = 1'b0;
         data_hold = 1'b0;
      end else begin
         if (inst_hold) begin
            check("inst held data_ok", inst_data_ok, 1);
            check("inst held rdata", inst_rdata, inst_hold_d);
         end
         if (data_hold) begin
            check("data held data_ok", data_data_ok, 1);
            check("data held rdata", data_rdata, data_hold_d);
         end
         if (inst_data_ok && inst_rsp_ready) begin
            check("inst rsp has pending request", inst_q.size() != 0, 1);
            if (inst_q.size() != 0) check("inst rdata", inst_rdata, inst_q.pop_front());
         end
         if (data_data_ok && data_rsp_ready) begin
            check("data rsp has pending request", data_q.size() != 0, 1);
            if (data_q.size() != 0) check("data rdata", data_rdata, data_q.pop_front());
         end
         inst_hold   = inst_data_ok && !inst_rsp_ready;
         inst_hold_d = inst_rdata;
         data_hold   = data_data_ok && !data_rsp_ready;
         data_hold_d = data_rdata;

         if (inst_addr_ok || data_addr_ok) begin
            check("single grant", inst_addr_ok && data_addr_ok, 0);
            check("sram_enabled on grant", sram_enabled, 1);
         end else begin
            check("sram idle command", {sram_enabled, sram_write_enabled}, 0);
         end
         if (inst_addr_ok) begin
            check("inst grant needs req", inst_req, 1);
            check("inst grant sram_address", sram_address, inst_address);
            check("inst grant no write", sram_write_enabled, 0);
            inst_q.push_back(ref_read(inst_address));
         end
         if (data_addr_ok) begin
            check("data grant needs req", data_req, 1);
            check("data grant sram_address", sram_address, data_address);
            if (data_write_enabled == 4'h0) begin
               data_q.push_back(ref_read(data_address));
            end else begin
               ref_write(data_address, data_write_enabled, data_write_data);
               data_q.push_back(32'h0);
            end
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   logic ig, dg, exp_inst;

   initial begin
      reset = 1'b1;
      inst_req = 1'b0; inst_address = '0; inst_rsp_ready = 1'b0;
      data_req = 1'b0; data_address = '0; data_write_enabled = '0; data_write_data = '0;
      data_rsp_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("reset inst_addr_ok", inst_addr_ok, 0);
      check("reset data_addr_ok", data_addr_ok, 0);
      check("reset inst_data_ok", inst_data_ok, 0);
      check("reset data_data_ok", data_data_ok, 0);
      check("reset inst_rdata", inst_rdata, 0);
      check("reset data_rdata", data_rdata, 0);
      check("reset sram_enabled", sram_enabled, 0);
      check("reset sram_write_enabled", sram_write_enabled, 0);

      // Single data read.
      step();
      reset = 1'b0;
      preload(32'h100, 32'hDEADBEEF);
      inst_rsp_ready = 1'b1;
      data_req = 1'b1; data_address = 32'h100; data_write_enabled = 4'h0; data_rsp_ready = 1'b1;
      @(negedge clock);
      check("read addr_ok", data_addr_ok, 1);
      check("read sram_address", sram_address, 32'h100);
      check("read sram_write_enabled", sram_write_enabled, 0);
      step();
      data_req = 1'b0;
      @(negedge clock);
      check("read data_ok", data_data_ok, 1);
      check("read rdata", data_rdata, 32'hDEADBEEF);

      // Partial write.
      step();
      data_req = 1'b1; data_address = 32'h20; data_write_enabled = 4'b0011;
      data_write_data = 32'h12345678;
      @(negedge clock);
      check("write addr_ok", data_addr_ok, 1);
      check("write sram strobes", sram_write_enabled, 4'b0011);
      check("write sram data", sram_write_data, 32'h12345678);
      step();
      data_req = 1'b0; data_write_enabled = 4'h0;
      @(negedge clock);
      check("write data_ok", data_data_ok, 1);
      check("write rdata", data_rdata, 0);

      // Continuous contention with both consumers ready; data was served last.
      step();
      inst_req = 1'b1; inst_address = 32'h40; data_req = 1'b1; data_address = 32'h44;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_inst = (i % 2 == 0);
`else
         exp_inst = 1'b0;
`endif
         check("tie inst_addr_ok", inst_addr_ok, exp_inst);
         check("tie data_addr_ok", data_addr_ok, !exp_inst);
         step();
      end
      inst_req = 1'b0; data_req = 1'b0;

      // Fetch back-pressure for three cycles while data traffic continues.
      @(negedge clock);
      step();
      preload(32'h40, 32'hCAFE0001);
      inst_req = 1'b1; inst_address = 32'h40; inst_rsp_ready = 1'b0;
      @(negedge clock);
      check("bp inst_addr_ok", inst_addr_ok, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         data_req = 1'b1; data_address = 32'h80 + 32'(4 * i);
         @(negedge clock);
         check("bp inst_data_ok", inst_data_ok, 1);
         check("bp inst_rdata", inst_rdata, 32'hCAFE0001);
         check("bp inst_addr_ok low", inst_addr_ok, 0);
         check("bp data_addr_ok", data_addr_ok, 1);
      end
      step();
      inst_rsp_ready = 1'b1; data_req = 1'b0;
      @(negedge clock);
      check("bp drain data_ok", inst_data_ok, 1);
      check("bp drain rdata", inst_rdata, 32'hCAFE0001);
      check("bp drain addr_ok low", inst_addr_ok, 0);
      step();
      @(negedge clock);
      check("bp held req granted", inst_addr_ok, 1);
      step();
      inst_req = 1'b0;

      // Reset the cycle after a grant.
      @(negedge clock);
      step();
      data_req = 1'b1; data_address = 32'h100; data_write_enabled = 4'h0; data_rsp_ready = 1'b1;
      @(negedge clock);
      check("rst grant", data_addr_ok, 1);
      step();
      reset = 1'b1; data_rsp_ready = 1'b0; inst_req = 1'b1; inst_address = 32'h40;
      @(negedge clock);
      check("rst data_data_ok", data_data_ok, 0);
      check("rst addr_ok", {inst_addr_ok, data_addr_ok}, 0);
      check("rst sram_enabled", sram_enabled, 0);
      step();
      reset = 1'b0; data_rsp_ready = 1'b1; inst_rsp_ready = 1'b1;
      @(negedge clock);
      check("post-rst inst_data_ok", inst_data_ok, 0);
      check("post-rst data_data_ok", data_data_ok, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_inst = 1'b1;
`else
      exp_inst = 1'b0;
`endif
      check("post-rst tie inst", inst_addr_ok, exp_inst);
      check("post-rst tie data", data_addr_ok, !exp_inst);
      step();
      inst_req = 1'b0; data_req = 1'b0;

      // Random traffic; requests are held until granted.
      for (int c = 0; c < 800; c++) begin
         @(negedge clock);
         ig = inst_addr_ok;
         dg = data_addr_ok;
         step();
         if (!inst_req || ig) begin
            inst_req     = ($urandom_range(0, 3) != 0);
            inst_address = 32'($urandom_range(0, 15)) << 2;
         end
         if (!data_req || dg) begin
            data_req           = ($urandom_range(0, 3) != 0);
            data_address       = 32'($urandom_range(0, 15)) << 2;
            data_write_enabled = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
            data_write_data    = $urandom;
         end
         inst_rsp_ready = ($urandom_range(0, 3) != 0);
         data_rsp_ready = ($urandom_range(0, 3) != 0);
      end
      @(negedge clock);
      ig = inst_addr_ok;
      dg = data_addr_ok;
      step();
      inst_req = 1'b0; data_req = 1'b0; inst_rsp_ready = 1'b1; data_rsp_ready = 1'b1;
      repeat (4) @(negedge clock);
      check("inst responses drained", inst_q.size(), 0);
      check("data responses drained", data_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
